// File: rtl/pwm_axi_lite_slave.sv
// pwm_axi_lite_slave
//   AXI4-Lite slave holding four 32-bit registers that drive a complementary
//   PWM generator with dead time.
//   Register map (byte address bits [3:2] select the register):
//     0x0 CTRL   bit0 EN, bit1 INV
//     0x4 PERIOD [15:0]
//     0x8 DUTY   [15:0]
//     0xC DEAD   [7:0]
//   Ports:
//     s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//     s00_axi_aw* / w* / b*          : AXI4-Lite write address, data, response
//     s00_axi_ar* / r*               : AXI4-Lite read address, data
//     pwm_h / pwm_l                  : high-side / low-side gate drives
module pwm_axi_lite_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              pwm_h,
  output logic                              pwm_l
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic          awready_q, awready_d;
  logic          bvalid_q,  bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [DW-1:0] ctrl_q,    ctrl_d;
  logic [DW-1:0] period_q,  period_d;
  logic [DW-1:0] duty_q,    duty_d;
  logic [DW-1:0] dead_q,    dead_d;
  logic [15:0]   cnt_q,     cnt_d;
  logic [15:0]   p_q,       p_d;
  logic [15:0]   d_q,       d_d;
  logic [7:0]    t_q,       t_d;
  logic          pwm_h_q,   pwm_h_d;
  logic          pwm_l_q,   pwm_l_d;

  logic          wrAccept, rdAccept;
  logic [DW-1:0] readMux;
  logic          en, inv, atWrap, hRaw, lRaw;
  logic [16:0]   cnt17, p17, d17, t17;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  function automatic logic [DW-1:0] mergeStrb(input logic [DW-1:0] oldVal,
                                              input logic [DW-1:0] newVal,
                                              input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = oldVal;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[i*8 +: 8] = newVal[i*8 +: 8];
    end
    return res;
  endfunction

  // A write is taken only with address and data both present and no
  // response outstanding; a read only with no read data outstanding.
  assign wrAccept = s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q;
  assign rdAccept = s00_axi_arvalid && !arready_q && !rvalid_q;

  always_comb begin
    readMux = ctrl_q;
    case (s00_axi_araddr[3:2])
      2'd0: readMux = ctrl_q;
      2'd1: readMux = period_q;
      2'd2: readMux = duty_q;
      default: readMux = dead_q;
    endcase
  end

  // Bus side. Read data is captured on the accept edge from the current
  // register contents, so a write accepted on that same edge is not seen.
  always_comb begin
    awready_d = wrAccept;
    bvalid_d  = bvalid_q ? !s00_axi_bready : awready_q;
    arready_d = rdAccept;
    rvalid_d  = rvalid_q ? !s00_axi_rready : arready_q;
    rdata_d   = rdAccept ? readMux : rdata_q;
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    duty_d    = duty_q;
    dead_d    = dead_q;
    if (wrAccept) begin
      case (s00_axi_awaddr[3:2])
        2'd0: ctrl_d   = mergeStrb(ctrl_q,   s00_axi_wdata, s00_axi_wstrb);
        2'd1: period_d = mergeStrb(period_q, s00_axi_wdata, s00_axi_wstrb);
        2'd2: duty_d   = mergeStrb(duty_q,   s00_axi_wdata, s00_axi_wstrb);
        default: dead_d = mergeStrb(dead_q,  s00_axi_wdata, s00_axi_wstrb);
      endcase
    end
  end

  // PWM side. Shadows reload at the wrap or while disabled, so a period in
  // progress always runs on a consistent set of values. Comparisons are
  // widened to 17 bits so D+T and cnt+T cannot wrap.
  always_comb begin
    en     = ctrl_q[0];
    inv    = ctrl_q[1];
    atWrap = (cnt_q == p_q);
    cnt_d  = (!en || atWrap) ? 16'd0 : cnt_q + 16'd1;
    p_d    = p_q;
    d_d    = d_q;
    t_d    = t_q;
    if (!en || atWrap) begin
      p_d = period_q[15:0];
      d_d = duty_q[15:0];
      t_d = dead_q[7:0];
    end
    cnt17   = {1'b0, cnt_q};
    p17     = {1'b0, p_q};
    d17     = {1'b0, d_q};
    t17     = {9'd0, t_q};
    hRaw    = en && (cnt17 >= t17) && (cnt17 < d17);
    lRaw    = en && (cnt17 >= d17 + t17) && (cnt17 + t17 <= p17);
    pwm_h_d = inv ? lRaw : hRaw;
    pwm_l_d = inv ? hRaw : lRaw;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      dead_q    <= '0;
      cnt_q     <= '0;
      p_q       <= '0;
      d_q       <= '0;
      t_q       <= '0;
      pwm_h_q   <= 1'b0;
      pwm_l_q   <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      dead_q    <= dead_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      d_q       <= d_d;
      t_q       <= t_d;
      pwm_h_q   <= pwm_h_d;
      pwm_l_q   <= pwm_l_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign pwm_h           = pwm_h_q;
  assign pwm_l           = pwm_l_q;

endmodule
